// File: rtl/sha256_pkg.sv
// SHA-256 shared types and constants.
// Used by the message-schedule block and its helpers.
package sha256_pkg;
  localparam int WORD_W     = 32;
  localparam int BLK_WORDS  = 16;
  localparam int NUM_ROUNDS = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_t;
endpackage

// File: rtl/sha256_sched_step.sv
// One schedule expansion step:
// W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
module sha256_sched_step
  import sha256_pkg::*;
(
  input  word_t w14,
  input  word_t w9,
  input  word_t w1,
  input  word_t w0,
  output word_t wn
);
  word_t s1;
  word_t s0;

  sha256_sigma1 u_s1 (
    .x (w14),
    .y (s1)
  );

  sha256_sigma0 u_s0 (
    .x (w1),
    .y (s0)
  );

  assign wn = s1 + w9 + s0 + w0;
endmodule

// File: rtl/sha256_sigma0.sv
// SHA-256 small sigma0:
// ror7 ^ ror18 ^ shr3.
module sha256_sigma0
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[6:0], x[31:7]}
           ^ {x[17:0], x[31:18]}
           ^ {3'b000, x[31:3]};
endmodule

// File: rtl/sha256_sigma1.sv
// SHA-256 small sigma1:
// ror17 ^ ror19 ^ shr10.
module sha256_sigma1
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[16:0], x[31:17]}
           ^ {x[18:0], x[31:19]}
           ^ {10'b0, x[31:10]};
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words,
// streams W0..W63 over a valid/ready port.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        w_last
);
  sched_state_t state;
  logic [5:0]   cnt;
  word_t        win [BLK_WORDS];
  word_t        nxt;
  logic         ld_fire;
  logic         em_fire;
  logic         ld_end;
  logic         em_end;

  assign ld_fire = (state == LOAD) && blk_valid;
  assign em_fire = (state == EMIT) && w_ready;
  assign ld_end  = cnt == 6'(BLK_WORDS - 1);
  assign em_end  = cnt == 6'(NUM_ROUNDS - 1);

  sha256_sched_step u_step (
    .w14 (win[14]),
    .w9  (win[9]),
    .w1  (win[1]),
    .w0  (win[0]),
    .wn  (nxt)
  );

  // Shared shift window: new words enter at the top in both phases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      for (int i = 0; i < BLK_WORDS; i++)
        win[i] <= '0;
    end else if (ld_fire || em_fire) begin
      for (int i = 0; i < BLK_WORDS - 1; i++)
        win[i] <= win[i+1];
      win[BLK_WORDS-1] <= ld_fire ? blk_word : nxt;
      if (ld_fire && ld_end) begin
        cnt   <= '0;
        state <= EMIT;
      end else if (em_fire && em_end) begin
        cnt   <= '0;
        state <= LOAD;
      end else begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  assign blk_ready = state == LOAD;
  assign w_valid   = state == EMIT;
  assign w_data    = win[0];
  assign w_idx     = cnt;
  assign w_last    = (state == EMIT) && em_end;
endmodule
